// File: rtl/ulpi_phy_emu.sv
// ULPI PHY emulator: link TX packets go out on m_axis, s_axis packets are returned to the link as RX data.
// Define ULPI_PHY_REGS_EN to build the writable register file at 0x04-0x3F.
module ulpi_phy_emu #(
    parameter logic [15:0] VENDOR_ID  = 16'h0424,
    parameter logic [15:0] PRODUCT_ID = 16'h0009,
    parameter logic [1:0]  LINESTATE  = 2'b01
) (
    input  logic       clock,
    input  logic       reset,
    output logic       ulpi_dir_o,
    output logic       ulpi_nxt_o,
    input  logic       ulpi_stp_i,
    input  logic [7:0] ulpi_data_i,
    output logic [7:0] ulpi_data_o,
    output logic       m_axis_tvalid_o,
    input  logic       m_axis_tready_i,
    output logic       m_axis_tlast_o,
    output logic [7:0] m_axis_tdata_o,
    input  logic       s_axis_tvalid_i,
    output logic       s_axis_tready_o,
    input  logic       s_axis_tlast_i,
    input  logic [7:0] s_axis_tdata_i
);

    localparam logic [7:0] RXCMD_ACTIVE = {2'b00, 2'b01, 2'b00, LINESTATE};
    localparam logic [7:0] RXCMD_END    = {4'h0, 2'b00, LINESTATE};

    typedef enum logic [3:0] {
        IDLE,
        TX_DATA,
        REG_WR,
        REG_WR_STP,
        RD_TURN,
        RD_DATA,
        RD_BACK,
        RX_TURN,
        RX_DATA,
        RX_END,
        RX_BACK
    } state_t;

    state_t     r_state;
    state_t     w_state_next;

    logic       w_dir;
    logic       w_nxt;
    logic [7:0] w_data;
    logic       w_s_ready;
    logic       w_load_pid;
    logic       w_tx_accept;
    logic       w_tx_stp;
    logic       w_latch_addr;

    logic [5:0] r_addr;
    logic [7:0] r_rd_data;
    logic [7:0] w_rd_value;
    logic       r_rx_abort;

    logic [7:0] r_buf;
    logic       r_buf_vld;
    logic       r_buf_last;
    logic [7:0] r_m_data;
    logic       r_m_valid;
    logic       r_m_last;
    logic       w_out_free;
    logic       w_flush;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_dir        = 1'b0;
        w_nxt        = 1'b0;
        w_data       = 8'h00;
        w_s_ready    = 1'b0;
        w_load_pid   = 1'b0;
        w_tx_accept  = 1'b0;
        w_tx_stp     = 1'b0;
        w_latch_addr = 1'b0;
        case (r_state)
            IDLE: begin
                // Pending RX traffic takes the bus; any TX CMD this cycle sees nxt=0 and is retried.
                if (s_axis_tvalid_i) begin
                    w_state_next = RX_TURN;
                end else begin
                    case (ulpi_data_i[7:6])
                        2'b01: begin
                            if (!r_buf_vld) begin
                                w_nxt        = 1'b1;
                                w_load_pid   = 1'b1;
                                w_state_next = TX_DATA;
                            end
                        end
                        2'b10: begin
                            w_nxt        = 1'b1;
                            w_latch_addr = 1'b1;
                            w_state_next = REG_WR;
                        end
                        2'b11: begin
                            w_nxt        = 1'b1;
                            w_latch_addr = 1'b1;
                            w_state_next = RD_TURN;
                        end
                        default: ;
                    endcase
                end
            end
            TX_DATA: begin
                w_nxt = m_axis_tready_i;
                if (ulpi_stp_i) begin
                    w_tx_stp     = 1'b1;
                    w_state_next = IDLE;
                end else if (m_axis_tready_i) begin
                    w_tx_accept = 1'b1;
                end
            end
            REG_WR: begin
                w_nxt        = 1'b1;
                w_state_next = ulpi_stp_i ? IDLE : REG_WR_STP;
            end
            REG_WR_STP: begin
                if (ulpi_stp_i) begin
                    w_state_next = IDLE;
                end
            end
            RD_TURN: begin
                w_dir        = 1'b1;
                w_state_next = RD_DATA;
            end
            RD_DATA: begin
                w_dir        = 1'b1;
                w_data       = r_rd_data;
                w_state_next = RD_BACK;
            end
            RD_BACK: begin
                w_state_next = IDLE;
            end
            RX_TURN: begin
                w_dir        = 1'b1;
                w_nxt        = 1'b1;
                w_state_next = RX_DATA;
            end
            RX_DATA: begin
                w_dir     = 1'b1;
                w_s_ready = 1'b1;
                // After a link stp the rest of the packet is drained silently up to tlast.
                if (s_axis_tvalid_i && !r_rx_abort) begin
                    w_nxt  = 1'b1;
                    w_data = s_axis_tdata_i;
                end else begin
                    w_data = RXCMD_ACTIVE;
                end
                if (s_axis_tvalid_i && s_axis_tlast_i) begin
                    w_state_next = RX_END;
                end
            end
            RX_END: begin
                w_dir        = 1'b1;
                w_data       = RXCMD_END;
                w_state_next = RX_BACK;
            end
            RX_BACK: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign ulpi_dir_o      = w_dir;
    assign ulpi_nxt_o      = w_nxt & ~reset;
    assign ulpi_data_o     = w_data;
    assign s_axis_tready_o = w_s_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_addr     <= 6'd0;
            r_rd_data  <= 8'h00;
            r_rx_abort <= 1'b0;
        end else begin
            if (w_latch_addr) begin
                r_addr <= ulpi_data_i[5:0];
            end
            if (r_state == RD_TURN) begin
                r_rd_data <= w_rd_value;
            end
            if (r_state == RX_TURN) begin
                r_rx_abort <= 1'b0;
            end else if (r_state == RX_DATA && ulpi_stp_i) begin
                r_rx_abort <= 1'b1;
            end
        end
    end

`ifdef ULPI_PHY_REGS_EN
    logic [7:0] r_regs [4:63];
    logic [7:0] r_wdata;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wdata <= 8'h00;
            for (int i = 4; i < 64; i++) begin
                r_regs[i] <= 8'h00;
            end
        end else begin
            if (r_state == REG_WR && !ulpi_stp_i) begin
                r_wdata <= ulpi_data_i;
            end
            if (r_state == REG_WR_STP && ulpi_stp_i && r_addr >= 6'd4) begin
                r_regs[r_addr] <= r_wdata;
            end
        end
    end
`endif

    always_comb begin
        w_rd_value = 8'h00;
        case (r_addr)
            6'h00: w_rd_value = VENDOR_ID[7:0];
            6'h01: w_rd_value = VENDOR_ID[15:8];
            6'h02: w_rd_value = PRODUCT_ID[7:0];
            6'h03: w_rd_value = PRODUCT_ID[15:8];
            default: begin
`ifdef ULPI_PHY_REGS_EN
                w_rd_value = r_regs[r_addr];
`endif
            end
        endcase
    end

    // One byte is held back so the byte before stp can be tagged as last.
    assign w_out_free = !r_m_valid || m_axis_tready_i;
    assign w_flush    = r_buf_vld && (r_buf_last || w_tx_stp) && w_out_free;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_buf      <= 8'h00;
            r_buf_vld  <= 1'b0;
            r_buf_last <= 1'b0;
            r_m_data   <= 8'h00;
            r_m_valid  <= 1'b0;
            r_m_last   <= 1'b0;
        end else begin
            if (r_m_valid && m_axis_tready_i) begin
                r_m_valid <= 1'b0;
            end
            if (w_load_pid) begin
                r_buf      <= {~ulpi_data_i[3:0], ulpi_data_i[3:0]};
                r_buf_vld  <= 1'b1;
                r_buf_last <= 1'b0;
            end else if (w_tx_accept) begin
                r_m_data  <= r_buf;
                r_m_last  <= 1'b0;
                r_m_valid <= 1'b1;
                r_buf     <= ulpi_data_i;
            end else if (w_flush) begin
                r_m_data   <= r_buf;
                r_m_last   <= 1'b1;
                r_m_valid  <= 1'b1;
                r_buf_vld  <= 1'b0;
                r_buf_last <= 1'b0;
            end else if (w_tx_stp) begin
                r_buf_last <= 1'b1;
            end
        end
    end

    assign m_axis_tvalid_o = r_m_valid;
    assign m_axis_tdata_o  = r_m_data;
    assign m_axis_tlast_o  = r_m_last;

endmodule
